// File: rtl/id_ex_reg.sv
// Decode-to-execute pipeline register: captures decoded fields each cycle, freezes on an
// ID-level stall, and collapses to a NOP bubble on a taken jump or an invalid decode slot.
module id_ex_reg #(
   parameter logic [31:0] NOP_INS       = 32'h0000_0013,
   parameter logic [2:0]  HOLD_ID_LEVEL = 3'd3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] ins_i,
   input  logic [31:0] ins_addr_i,
   input  logic [6:0]  opcode_i,
   input  logic [2:0]  funct3_i,
   input  logic [6:0]  funct7_i,
   input  logic [31:0] imm_i,
   input  logic [4:0]  rs1_addr_i,
   input  logic [4:0]  rs2_addr_i,
   input  logic [31:0] reg1_rd_data_i,
   input  logic [31:0] reg2_rd_data_i,
   input  logic [4:0]  reg_wr_addr_i,
   input  logic        valid_i,
   input  logic [2:0]  hold_flag_i,
   input  logic        jump_flag_i,
   input  logic        wb_en_i,
   input  logic [4:0]  wb_addr_i,
   input  logic [31:0] wb_data_i,
   output logic [31:0] ins_o,
   output logic [31:0] ins_addr_o,
   output logic [6:0]  opcode_o,
   output logic [2:0]  funct3_o,
   output logic [6:0]  funct7_o,
   output logic [31:0] imm_o,
   output logic [4:0]  rs1_addr_o,
   output logic [4:0]  rs2_addr_o,
   output logic [31:0] reg1_rd_data_o,
   output logic [31:0] reg2_rd_data_o,
   output logic [4:0]  reg_wr_addr_o,
   output logic        valid_o
);

   localparam logic [6:0] NOP_OPCODE = 7'b0010011;

   logic [31:0] ins_q, ins_d, ins_addr_q, ins_addr_d, imm_q, imm_d;
   logic [6:0]  opcode_q, opcode_d, funct7_q, funct7_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [4:0]  rs1_addr_q, rs1_addr_d, rs2_addr_q, rs2_addr_d, reg_wr_addr_q, reg_wr_addr_d;
   logic [31:0] reg1_q, reg1_d, reg2_q, reg2_d;
   logic        valid_q, valid_d;

   logic stall;
   logic load_bubble;
   logic wb_live;

   assign stall       = (hold_flag_i >= HOLD_ID_LEVEL);
   assign load_bubble = jump_flag_i || (!stall && !valid_i);
   // x0 is hard-wired zero, so a writeback to it never counts as a match
   assign wb_live     = wb_en_i && (wb_addr_i != 5'd0);

   always_comb begin
      ins_d         = ins_q;
      ins_addr_d    = ins_addr_q;
      opcode_d      = opcode_q;
      funct3_d      = funct3_q;
      funct7_d      = funct7_q;
      imm_d         = imm_q;
      rs1_addr_d    = rs1_addr_q;
      rs2_addr_d    = rs2_addr_q;
      reg1_d        = reg1_q;
      reg2_d        = reg2_q;
      reg_wr_addr_d = reg_wr_addr_q;
      valid_d       = valid_q;

      if (load_bubble) begin
         ins_d         = NOP_INS;
         ins_addr_d    = 32'd0;
         opcode_d      = NOP_OPCODE;
         funct3_d      = 3'd0;
         funct7_d      = 7'd0;
         imm_d         = 32'd0;
         rs1_addr_d    = 5'd0;
         rs2_addr_d    = 5'd0;
         reg1_d        = 32'd0;
         reg2_d        = 32'd0;
         reg_wr_addr_d = 5'd0;
         valid_d       = 1'b0;
      end else if (stall) begin
         // Held operands still pick up late writebacks (e.g. a divider finishing mid-stall)
         if (wb_live && (wb_addr_i == rs1_addr_q)) reg1_d = wb_data_i;
         if (wb_live && (wb_addr_i == rs2_addr_q)) reg2_d = wb_data_i;
      end else begin
         ins_d         = ins_i;
         ins_addr_d    = ins_addr_i;
         opcode_d      = opcode_i;
         funct3_d      = funct3_i;
         funct7_d      = funct7_i;
         imm_d         = imm_i;
         rs1_addr_d    = rs1_addr_i;
         rs2_addr_d    = rs2_addr_i;
         reg1_d        = (wb_live && (wb_addr_i == rs1_addr_i)) ? wb_data_i : reg1_rd_data_i;
         reg2_d        = (wb_live && (wb_addr_i == rs2_addr_i)) ? wb_data_i : reg2_rd_data_i;
         reg_wr_addr_d = reg_wr_addr_i;
         valid_d       = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ins_q         <= NOP_INS;
         ins_addr_q    <= 32'd0;
         opcode_q      <= NOP_OPCODE;
         funct3_q      <= 3'd0;
         funct7_q      <= 7'd0;
         imm_q         <= 32'd0;
         rs1_addr_q    <= 5'd0;
         rs2_addr_q    <= 5'd0;
         reg1_q        <= 32'd0;
         reg2_q        <= 32'd0;
         reg_wr_addr_q <= 5'd0;
         valid_q       <= 1'b0;
      end else begin
         ins_q         <= ins_d;
         ins_addr_q    <= ins_addr_d;
         opcode_q      <= opcode_d;
         funct3_q      <= funct3_d;
         funct7_q      <= funct7_d;
         imm_q         <= imm_d;
         rs1_addr_q    <= rs1_addr_d;
         rs2_addr_q    <= rs2_addr_d;
         reg1_q        <= reg1_d;
         reg2_q        <= reg2_d;
         reg_wr_addr_q <= reg_wr_addr_d;
         valid_q       <= valid_d;
      end
   end

   assign ins_o          = ins_q;
   assign ins_addr_o     = ins_addr_q;
   assign opcode_o       = opcode_q;
   assign funct3_o       = funct3_q;
   assign funct7_o       = funct7_q;
   assign imm_o          = imm_q;
   assign rs1_addr_o     = rs1_addr_q;
   assign rs2_addr_o     = rs2_addr_q;
   assign reg1_rd_data_o = reg1_q;
   assign reg2_rd_data_o = reg2_q;
   assign reg_wr_addr_o  = reg_wr_addr_q;
   assign valid_o        = valid_q;

endmodule
